// File: rtl/apb_rx_seq.sv
// apb_rx_seq: start-bit-qualified UART receive frame sequencer for the APB RX path.
// Synchronises rx_in, detects the start edge, samples each bit mid-period using
// a clamped 20-bit baud divisor, checks optional even parity, and hands completed
// bytes to the APB side over a valid/ack handshake. Frame, parity and overrun
// errors are sticky until err_clr.
//
// Optional build macro: RX_MAJORITY_VOTE_EN -- each bit is the 2-of-3 majority
// of rx_s around the nominal sample point (port list unchanged).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rx_en                 receiver enable (low aborts any frame in progress)
//   mode                  0 = 8N1, 1 = 8E1
//   baud[19:0]            clk cycles per bit (floored at MIN_BAUD)
//   rx_in                 serial line, idle high
//   rx_ack                APB has read rx_data (1-cycle pulse)
//   err_clr               clear sticky errors (1-cycle pulse)
//   rx_data, rx_valid     last accepted byte / unread flag
//   busy                  frame in progress
//   frame_err, parity_err, overrun   sticky error flags
module apb_rx_seq #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_BAUD    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              mode,
    input  logic [19:0]       baud,
    input  logic              rx_in,
    input  logic              rx_ack,
    input  logic              err_clr,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam int unsigned CNT_W = 20;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s;
    logic                 rx_prev;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     eff_q;
    logic [CNT_W-1:0]     eff_c;
    logic [CNT_W-1:0]     point;
    logic                 mode_q;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_W-1:0]    shreg;
    logic                 par_bad;
    logic                 hit;
    logic                 samp;
    logic                 sample_now;
    logic                 commit;
    logic                 start_go;
    logic                 accept;
    logic                 frame_set;
    logic                 par_set;
    logic                 ovr_set;

    assign rx_s  = sync_q[SYNC_STAGES-1];
    assign eff_c = (baud < CNT_W'(MIN_BAUD)) ? CNT_W'(MIN_BAUD) : baud;
    // Start bit is sampled at half a period; all later bits one full period on.
    assign point = (state_q == START) ? (eff_q >> 1) : (eff_q - CNT_W'(1));

`ifdef RX_MAJORITY_VOTE_EN
    // Decide one cycle after the nominal point so three samples are available;
    // restarting the counter at 1 keeps the bit period unchanged.
    localparam logic [CNT_W-1:0] CNT_RESTART = CNT_W'(1);
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= {hist_q[0], rx_s};
    end

    assign hit  = (cnt_q == point + CNT_W'(1));
    assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    localparam logic [CNT_W-1:0] CNT_RESTART = '0;
    assign hit  = (cnt_q == point);
    assign samp = rx_s;
`endif

    // Input synchroniser, idle-high reset so no false start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_d    = state_q;
        start_go   = 1'b0;
        sample_now = 1'b0;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_en && rx_prev && !rx_s) begin
                    state_d  = START;
                    start_go = 1'b1;
                end
            end
            START: begin
                if (hit) state_d = samp ? IDLE : DATA;
            end
            DATA: begin
                if (hit && bit_idx == IDX_W'(DATA_W - 1))
                    state_d = mode_q ? PARITY : STOP;
            end
            PARITY: begin
                if (hit) state_d = STOP;
            end
            STOP: begin
                if (hit) begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            if (!rx_en) begin
                state_d = IDLE;
                commit  = 1'b0;
            end else begin
                sample_now = hit;
            end
        end
        accept    = commit & (~rx_valid | rx_ack);
        ovr_set   = commit & rx_valid & ~rx_ack;
        frame_set = commit & ~samp;
        par_set   = commit & mode_q & par_bad;
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev    <= 1'b1;
            cnt_q      <= '0;
            eff_q      <= '0;
            mode_q     <= 1'b0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_prev <= rx_s;
            busy    <= (state_d != IDLE);

            if (state_q == IDLE || !rx_en) cnt_q <= '0;
            else if (hit)                  cnt_q <= CNT_RESTART;
            else                           cnt_q <= cnt_q + CNT_W'(1);

            if (start_go) begin
                eff_q   <= eff_c;
                mode_q  <= mode;
                bit_idx <= '0;
                par_bad <= 1'b0;
            end

            if (sample_now && state_q == DATA) begin
                shreg   <= {samp, shreg[DATA_W-1:1]};
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (sample_now && state_q == PARITY)
                par_bad <= samp ^ (^shreg);

            if (accept) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            // Sets win over a simultaneous clear.
            frame_err  <= (frame_err  & ~err_clr) | frame_set;
            parity_err <= (parity_err & ~err_clr) | par_set;
            overrun    <= (overrun    & ~err_clr) | ovr_set;
        end
    end

endmodule

// File: tb/tb_apb_rx_seq.sv
// Testbench for apb_rx_seq: drives UART frames bit by bit and compares outputs
// against a frame-level reference model of the receive/handshake/error rules.
module tb_apb_rx_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en;
    logic        mode;
    logic [19:0] baud;
    logic        rx_in;
    logic        rx_ack;
    logic        err_clr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_data;
    logic       m_valid, m_fe, m_pe, m_ov;

    always #5 clk = ~clk;

    apb_rx_seq #(.DATA_W(8), .SYNC_STAGES(2), .MIN_BAUD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_en      (rx_en),
        .mode       (mode),
        .baud       (baud),
        .rx_in      (rx_in),
        .rx_ack     (rx_ack),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rx_data"},    32'(rx_data),    32'(m_data));
        check({tag, ".rx_valid"},   32'(rx_valid),   32'(m_valid));
        check({tag, ".frame_err"},  32'(frame_err),  32'(m_fe));
        check({tag, ".parity_err"}, 32'(parity_err), 32'(m_pe));
        check({tag, ".overrun"},    32'(overrun),    32'(m_ov));
        check({tag, ".busy"},       32'(busy),       32'd0);
    endtask

    task automatic model_reset();
        m_data = '0; m_valid = 0; m_fe = 0; m_pe = 0; m_ov = 0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1; step(1); rx_ack = 0;
        m_valid = 0;
        step(1);
    endtask

    task automatic pulse_clr();
        err_clr = 1; step(1); err_clr = 0;
        m_fe = 0; m_pe = 0; m_ov = 0;
        step(1);
    endtask

    // Drives one frame starting now. abort_at >= 0 drops rx_en at that cycle.
    // Baud and mode are scrambled mid-frame; the latched values must hold.
    task automatic send_frame(input logic [19:0] b, input logic m, input logic [7:0] d,
                              input logic pbit, input logic sbit, input logic ack_commit,
                              input int abort_at);
        int   eff, nbits, n_commit, last, rise, k;
        logic v, was_valid;
        eff       = (b < 20'd4) ? 4 : int'(b);
        nbits     = m ? 11 : 10;
        // 3 cycles to reach START, stop sample after eff/2 + (nbits-1)*eff, +1 to register
        n_commit  = 4 + eff / 2 + (nbits - 1) * eff;
        last      = ((nbits * eff > n_commit) ? nbits * eff : n_commit) + 4;
        baud      = b;
        mode      = m;
        rise      = -1;
        was_valid = m_valid;
        for (int c = 0; c < last; c++) begin
            k = c / eff;
            if (k == 0)          v = 1'b0;
            else if (k <= 8)     v = d[k-1];
            else if (k < nbits)  v = (m && k == 9) ? pbit : sbit;
            else                 v = 1'b1;
            rx_in  = v;
            rx_ack = ack_commit && (c == n_commit - 1);
            if (c == 2 * eff) begin
                baud = 20'($urandom_range(1, 40));
                mode = ~m;
            end
            if (c == abort_at) begin
                rx_en = 0;
                rx_in = 1;
                step(1);
                check("abort_busy", 32'(busy), 32'd0);
                rx_en = 1;
                step(2 * eff + 4);
                return;
            end
            @(posedge clk);
            #1;
            if (rx_valid && rise < 0) rise = c + 1;
        end
        rx_ack = 0;
        rx_in  = 1;
        if (!sbit) m_fe = 1;
        if (m && (pbit != ^d)) m_pe = 1;
        if (!m_valid || ack_commit) begin
            m_data  = d;
            m_valid = 1;
        end else begin
            m_ov = 1;
        end
        if (!was_valid) check("latency", 32'(rise), 32'(n_commit));
    endtask

    initial begin
        rst = 1; rx_en = 1; mode = 0; baud = 20'd16;
        rx_in = 1; rx_ack = 0; err_clr = 0;
        model_reset();
        step(3);
        rst = 0;
        step(2);
        check_all("reset");

        // 8N1 basic frame with exact latency
        send_frame(20'd16, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, -1);
        check_all("a5_8n1");

        // 8E1 with wrong parity, then clear
        pulse_ack();
        send_frame(20'd16, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, -1);
        check_all("3c_badpar");
        pulse_clr();
        check_all("3c_clr");

        // Overrun without ack, then ack on the commit cycle
        pulse_ack();
        send_frame(20'd16, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, -1);
        send_frame(20'd16, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, -1);
        check_all("overrun");
        pulse_clr();
        pulse_ack();
        send_frame(20'd16, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, -1);
        send_frame(20'd16, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1, -1);
        check_all("ack_commit");

        // Short low glitch: start qualifies then aborts
        baud = 20'd16; mode = 0;
        rx_in = 0; step(4); rx_in = 1;
        check("glitch_busy", 32'(busy), 32'd1);
        step(30);
        check_all("glitch");

        // Bad stop bit, then rx_en dropped mid-DATA
        pulse_ack();
        send_frame(20'd16, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, -1);
        check_all("stop_low");
        send_frame(20'd16, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3 + 8 + 40);
        check_all("abort");

        // Divisor clamp
        pulse_clr();
        pulse_ack();
        send_frame(20'd1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, -1);
        check_all("clamp");

        // Randomised frames
        for (int i = 0; i < 24; i++) begin
            logic [7:0]  d;
            logic        m, pb, sb, ac;
            logic [19:0] b;
            d  = 8'($urandom);
            m  = 1'($urandom);
            b  = 20'($urandom_range(1, 20));
            pb = ($urandom_range(0, 9) < 8) ? ^d : ~^d;
            sb = ($urandom_range(0, 9) < 8);
            ac = ($urandom_range(0, 3) == 0);
            send_frame(b, m, d, pb, sb, ac, -1);
            check_all("rand");
            if ($urandom_range(0, 1) == 1) pulse_ack();
            if ($urandom_range(0, 4) == 0) pulse_clr();
            step(2);
        end

        // Async reset mid-DATA
        pulse_ack();
        send_frame(20'd16, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, -1);
        baud = 20'd16; mode = 0;
        rx_in = 0;
        step(40);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1;
        #1;
        model_reset();
        check_all("async_rst");
        rx_in = 1;
        step(2);
        rst = 0;
        step(3);
        check_all("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_rx_seq.md
Name: apb_rx_seq

Overview:
Frame sequencer for the UART APB receive path, replacing the free-running bit/baud counting with a start-bit-qualified state machine.
- Synchronises rx_in, detects the start edge and times mid-bit sampling from a 20-bit baud divisor.
- Sequences the data, parity and stop bits, then hands each completed byte to the APB side over a valid/ack handshake.
- Raises sticky frame, parity and overrun errors.

Parameters:
DATA_W, 8, data bits per frame (LSB first)
SYNC_STAGES, 2, rx_in synchroniser depth (minimum 2)
MIN_BAUD, 4, floor applied to the baud divisor

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_en  in  1  receiver enable
mode  in  1  0 = 8N1, 1 = 8E1 (even parity bit after the data bits)
baud  in  20  clk cycles per bit
rx_in  in  1  serial line, idle high
rx_ack  in  1  1-cycle pulse: APB has read rx_data
err_clr  in  1  1-cycle pulse: clear sticky errors
rx_data  out  DATA_W  last accepted byte
rx_valid  out  1  rx_data unread
busy  out  1  state != IDLE
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch (mode 1 only)
overrun  out  1  sticky: frame completed while rx_valid=1 and no rx_ack

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; synchroniser flops and rx_prev = 1; counters 0.
- rx_s: rx_in after SYNC_STAGES flops. rx_prev: rx_s delayed one cycle.
- Divisor: eff_baud = max(baud, MIN_BAUD). eff_baud and mode are latched on leaving IDLE; later changes have no effect mid-frame.
- cnt: 20-bit counter; increments each cycle outside IDLE; cleared on every state transition and on every sample.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if rx_en & rx_prev & ~rx_s, go to START with cnt=0.
  - START: when cnt == eff_baud>>1, sample rx_s. If 0, go to DATA with bit_idx=0. If 1 (glitch), return to IDLE with no flags changed.
  - DATA: when cnt == eff_baud-1, shift rx_s into shreg[DATA_W-1] (right shift, LSB first) and increment bit_idx. After bit DATA_W-1, go to PARITY if mode=1, else STOP.
  - PARITY: when cnt == eff_baud-1, compute par_bad = rx_s ^ (^shreg), then go to STOP.
  - STOP: when cnt == eff_baud-1, sample, then commit and go to IDLE.
- Commit, one cycle after the stop sample (the registered update):
  - frame_err |= ~stop_sample.
  - parity_err |= par_bad (mode 1 only).
  - If rx_valid=0 or rx_ack is high this cycle: rx_data <= shreg and rx_valid <= 1.
  - Otherwise rx_data is kept, the new byte is dropped and overrun <= 1.
  - Errors of the committed frame are flagged even when the byte is dropped.
- rx_ack with no commit clears rx_valid. rx_ack while rx_valid=0 has no effect.
- err_clr clears all three sticky flags. A set in the same cycle wins.
- rx_en low in any non-IDLE state: go to IDLE next cycle and discard the partial frame. rx_data, rx_valid and flags are kept.
- Line held low after a frame (break): no new start until rx_s returns high, because edge detection requires rx_prev=1.
- Latency, 8N1: the stop sample occurs eff_baud/2 + (DATA_W+1)*eff_baud cycles after START entry. rx_valid rises 1 cycle later.

Optional Feature:
RX_MAJORITY_VOTE_EN
- Defined: every sample (start, data, parity, stop) is the 2-of-3 majority of rx_s at cnt = point-1, point and point+1, where point is the nominal sample count. The state transition moves to point+1, and cnt restarts at 0 with an extra offset of 1 so the bit period is unchanged.
- Undefined: single sample at the nominal point, as above. Port list is identical in both builds.

Test Plan:
- baud=16, mode 0, send 0xA5 8N1 -> rx_data=0xA5, rx_valid=1 at 1+8+144 cycles after START entry; all flags 0; busy low afterwards.
- baud=16, mode 1, send 0x3C with parity bit 1 (wrong; even parity requires 0) -> rx_data=0x3C, parity_err=1; err_clr pulse -> parity_err=0.
- Two frames 0x11 then 0x22 with no rx_ack -> rx_data stays 0x11, overrun=1. Repeat with rx_ack pulsed on the commit cycle -> rx_data=0x22, rx_valid=1, overrun=0.
- Low pulse of 4 cycles on rx_in at baud=16 -> START aborts to IDLE; rx_valid, rx_data and flags unchanged.
- Stop bit driven 0 with data 0xFF -> frame_err=1, rx_data=0xFF. rx_en dropped mid-DATA on the next frame -> IDLE within 1 cycle, rx_data still 0xFF.
- baud=1 -> clamped to 4; 0x5A received correctly. Assert rst mid-DATA -> all outputs 0 immediately.
